serial_add_collector: RTL and testbench

- Downstream stage of the bit-level half adder (sum = a^b, carry = a&b).
- Consumes one half-adder sum/carry pair per accepted cycle, LSB first.
- Folds in a registered carry so the pair of stages forms a bit-serial full adder.
- Assembles the WIDTH+1-bit result and presents it on a valid/ready output handshake.

---
 rtl/serial_add_collector_if.sv | 26 ++
 rtl/serial_add_collector.sv | 106 ++++++++++
 tb/tb_serial_add_collector.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/serial_add_collector_if.sv
// Bit-pair input and result output bundle for the serial add collector.
// Carries the start pulse, input handshake, output handshake and status flags.
interface serial_add_collector_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic             ha_sum;
    logic             ha_carry;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   result;
    logic             busy;
    logic             err;

    modport master (
        output start, in_valid, ha_sum, ha_carry, out_ready,
        input  in_ready, out_valid, result, busy, err
    );

    modport slave (
        input  start, in_valid, ha_sum, ha_carry, out_ready,
        output in_ready, out_valid, result, busy, err
    );
endinterface

// File: rtl/serial_add_collector.sv
// Downstream half of a bit-serial full adder: folds a registered carry into
// half-adder sum/carry pairs (LSB first) and presents the WIDTH+1 bit sum.
module serial_add_collector #(
    parameter int WIDTH = 8
) (
    input logic clk,
    input logic rst,
    serial_add_collector_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic           carry_q, carry_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH:0] result_q, result_d;
    logic [CW-1:0]  count_q, count_d;
    logic           err_q, err_d;

    logic           s_bit;
    logic           carry_nx;
    logic           last;

    always_comb begin
        state_d  = state_q;
        carry_d  = carry_q;
        shift_d  = shift_q;
        result_d = result_q;
        count_d  = count_q;
        err_d    = err_q;

        s_bit    = bus.ha_sum ^ carry_q;
        carry_nx = bus.ha_carry | (bus.ha_sum & carry_q);
        last     = (count_q == CW'(WIDTH - 1));

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    carry_d = 1'b0;
                    shift_d = '0;
                    count_d = '0;
                    err_d   = 1'b0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                // A start here restarts the operation and drops any pair.
                if (bus.start) begin
                    carry_d = 1'b0;
                    shift_d = '0;
                    count_d = '0;
                    err_d   = 1'b0;
                end else if (bus.in_valid) begin
                    carry_d = carry_nx;
                    shift_d = {s_bit, shift_q[WIDTH-1:1]};
                    count_d = count_q + 1'b1;
                    if (bus.ha_sum && bus.ha_carry) begin
                        err_d = 1'b1;
                    end
                    if (last) begin
                        result_d = {carry_nx, s_bit, shift_q[WIDTH-1:1]};
                        count_d  = '0;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            carry_q  <= 1'b0;
            shift_q  <= '0;
            result_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            carry_q  <= carry_d;
            shift_q  <= shift_d;
            result_q <= result_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.result    = result_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_serial_add_collector.sv
// Directed and random operations checked against a + b computed
// arithmetically, including bubbles, backpressure, abort and reset cases.
module tb_serial_add_collector;
    localparam int W = 8;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    serial_add_collector_if #(.WIDTH(W)) bus ();

    serial_add_collector #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic feed_pair(input logic s, input logic c);
        bus.in_valid = 1'b1;
        bus.ha_sum   = s;
        bus.ha_carry = c;
        tick();
        bus.in_valid = 1'b0;
    endtask

    // bub: 0 none, 1 every other cycle, 2 random. bad_bit < 0: all legal.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int bub, input int bp, input int bad_bit,
                          input bit dn_start);
        logic [W:0] exp;
        logic       err_exp;
        exp     = {1'b0, a} + {1'b0, b};
        err_exp = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("start_busy", bus.busy, 1);
        chk("start_rdy", bus.in_ready, 1);
        chk("start_err", bus.err, 0);
        for (int i = 0; i < W; i++) begin
            if (i > 0 && (bub == 1 || (bub == 2 && $urandom_range(0, 1) == 1))) begin
                bus.in_valid = 1'b0;
                tick();
                chk("bubble_ov", bus.out_valid, 0);
                chk("bubble_rdy", bus.in_ready, 1);
            end
            if (i == bad_bit) begin
                err_exp = 1'b1;
                feed_pair(1'b1, 1'b1);
            end else begin
                feed_pair(a[i] ^ b[i], a[i] & b[i]);
            end
            chk("acc_ov", bus.out_valid, (i == W - 1));
            chk("acc_rdy", bus.in_ready, (i != W - 1));
            chk("acc_err", bus.err, err_exp);
        end
        if (bad_bit < 0) chk("result", bus.result, exp);
        for (int k = 0; k < bp; k++) begin
            bus.out_ready = 1'b0;
            bus.start     = dn_start && (k == 0);
            tick();
            bus.start = 1'b0;
            chk("hold_ov", bus.out_valid, 1);
            chk("hold_busy", bus.busy, 1);
            chk("hold_err", bus.err, err_exp);
            if (bad_bit < 0) chk("hold_res", bus.result, exp);
        end
        bus.out_ready = 1'b1;
        bus.start     = dn_start;
        tick();
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        chk("drain_ov", bus.out_valid, 0);
        chk("drain_busy", bus.busy, 0);
        chk("drain_rdy", bus.in_ready, 0);
        chk("drain_err", bus.err, err_exp);
        if (bad_bit < 0) chk("drain_res", bus.result, exp);
        if (dn_start) begin
            tick();
            chk("no_latch_busy", bus.busy, 0);
        end
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        total = 0;
        bad   = 0;
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.ha_sum    = 1'b0;
        bus.ha_carry  = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", bus.busy, 0);
        chk("rst_rdy", bus.in_ready, 0);
        chk("rst_ov", bus.out_valid, 0);
        chk("rst_res", bus.result, 0);
        chk("rst_err", bus.err, 0);

        // Pairs offered while idle must be ignored.
        feed_pair(1'b1, 1'b0);
        chk("idle_busy", bus.busy, 0);

        run_op(8'h5A, 8'h33, 0, 0, -1, 1'b0);
        run_op(8'hFF, 8'h01, 0, 1, -1, 1'b0);
        run_op(8'h80, 8'h80, 1, 5, -1, 1'b0);

        run_op(8'h12, 8'h40, 0, 2, 3, 1'b0);
        chk("idle_err_sticky", bus.err, 1);
        run_op(8'h0F, 8'hF0, 0, 1, -1, 1'b0);

        run_op(8'hC3, 8'h3C, 0, 2, -1, 1'b1);

        // Abort after four accepts; the pair offered with start is dropped.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        feed_pair(1'b1, 1'b1);
        feed_pair(1'b0, 1'b1);
        feed_pair(1'b1, 1'b0);
        feed_pair(1'b0, 1'b1);
        chk("pre_abort_err", bus.err, 1);
        bus.start    = 1'b1;
        bus.in_valid = 1'b1;
        bus.ha_sum   = 1'b1;
        bus.ha_carry = 1'b1;
        tick();
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        chk("abort_busy", bus.busy, 1);
        chk("abort_rdy", bus.in_ready, 1);
        chk("abort_err", bus.err, 0);
        for (int i = 0; i < W; i++) feed_pair(1'b0, (i == 0));
        chk("abort_ov", bus.out_valid, 1);
        chk("abort_res", bus.result, 9'h002);
        chk("abort_err2", bus.err, 0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("abort_drain", bus.busy, 0);

        // Reset after five accepts.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) feed_pair(1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_busy", bus.busy, 0);
        chk("mrst_rdy", bus.in_ready, 0);
        chk("mrst_ov", bus.out_valid, 0);
        chk("mrst_res", bus.result, 0);
        chk("mrst_err", bus.err, 0);
        run_op(8'hA7, 8'h6E, 0, 0, -1, 1'b0);

        for (int n = 0; n < 20; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            run_op(ra, rb, 2, int'($urandom_range(0, 3)), -1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
